// File: rtl/cmac_rx_pkt_pkg.sv
// Shared types and helpers for the CMAC RX store-and-forward packet filter.
package cmac_rx_pkt_pkg;

  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam int BEAT_W = DATA_W + KEEP_W + 1;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } wr_state_e;

  // Saturating increment; callers pass their all-ones value as max_val.
  function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input logic [63:0] max_val);
    if (cnt == max_val) begin
      return cnt;
    end else begin
      return cnt + 64'd1;
    end
  endfunction

endpackage

// File: rtl/cmac_rx_pkt_ram.sv
// Simple dual-port beat RAM with one-cycle registered read.
module cmac_rx_pkt_ram
  import cmac_rx_pkt_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BEAT_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BEAT_W-1:0] rdata
);

  logic [BEAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cmac_rx_pkt_filter.sv
// Store-and-forward RX filter: only complete, FCS-good packets reach the user side;
// errored or overflowing packets are rolled back before any beat becomes readable.
module cmac_rx_pkt_filter
  import cmac_rx_pkt_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = 32
) (
  input  logic              cmac_clk,
  input  logic              cmac_reset,
  input  logic [DATA_W-1:0] cmac_rx_tdata,
  input  logic [KEEP_W-1:0] cmac_rx_tkeep,
  input  logic              cmac_rx_tuser,
  input  logic              cmac_rx_tlast,
  input  logic              cmac_rx_tvalid,
  output logic [DATA_W-1:0] user_rx_tdata,
  output logic [KEEP_W-1:0] user_rx_tkeep,
  output logic              user_rx_tuser,
  output logic              user_rx_tlast,
  output logic              user_rx_tvalid,
  input  logic              user_rx_tready,
  input  logic              clear_counters,
  output logic [CNT_W-1:0]  good_count,
  output logic [CNT_W-1:0]  err_drop_count,
  output logic [CNT_W-1:0]  ovf_drop_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wr_state_e state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, commit_nxt;
  logic full, wr_en, inc_good, inc_err, inc_ovf;
  logic avail, rd_en, rd_pend, pop, skid_vld;
  logic [1:0] occ_after;
  logic [BEAT_W-1:0] ram_q, skid;

  // Full uses the registered rd_ptr, so a same-cycle read never frees space early.
  assign full = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    inc_good   = 1'b0;
    inc_err    = 1'b0;
    inc_ovf    = 1'b0;
    case (state)
      SYNC: begin
        if (!cmac_rx_tvalid || cmac_rx_tlast) begin
          state_nxt = RECV;
        end else begin
          state_nxt = SYNC;
        end
      end
      RECV: begin
        if (cmac_rx_tvalid && !full) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = wr_ptr + PTR_W'(1);
          if (cmac_rx_tlast && !cmac_rx_tuser) begin
            commit_nxt = wr_ptr + PTR_W'(1);
            inc_good   = 1'b1;
          end else if (cmac_rx_tlast) begin
            wr_ptr_nxt = commit_ptr;
            inc_err    = 1'b1;
          end else begin
            inc_good   = 1'b0;
          end
        end else if (cmac_rx_tvalid) begin
          wr_ptr_nxt = commit_ptr;
          inc_ovf    = 1'b1;
          state_nxt  = cmac_rx_tlast ? RECV : DISCARD;
        end else begin
          state_nxt  = RECV;
        end
      end
      DISCARD: begin
        if (cmac_rx_tvalid && cmac_rx_tlast) begin
          state_nxt = RECV;
        end else begin
          state_nxt = DISCARD;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge cmac_clk) begin
    if (cmac_reset) begin
      state      <= SYNC;
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_nxt;
    end
  end

  always_ff @(posedge cmac_clk) begin
    if (cmac_reset || clear_counters) begin
      good_count     <= '0;
      err_drop_count <= '0;
      ovf_drop_count <= '0;
    end else begin
      if (inc_good) good_count     <= CNT_W'(sat_inc(64'(good_count), 64'(CNT_MAX)));
      if (inc_err)  err_drop_count <= CNT_W'(sat_inc(64'(err_drop_count), 64'(CNT_MAX)));
      if (inc_ovf)  ovf_drop_count <= CNT_W'(sat_inc(64'(ovf_drop_count), 64'(CNT_MAX)));
    end
  end

  cmac_rx_pkt_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (cmac_clk),
    .we    (wr_en),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({cmac_rx_tdata, cmac_rx_tkeep, cmac_rx_tlast}),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  // Issue a read only if the beat will have a slot in the 2-entry output stage.
  assign avail     = rd_ptr != commit_ptr;
  assign pop       = user_rx_tvalid & user_rx_tready;
  assign occ_after = {1'b0, user_rx_tvalid} + {1'b0, skid_vld} + {1'b0, rd_pend} - {1'b0, pop};
  assign rd_en     = avail && (occ_after <= 2'd1);
  assign user_rx_tuser = 1'b0;

  always_ff @(posedge cmac_clk) begin
    if (cmac_reset) begin
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge cmac_clk) begin
    if (cmac_reset) begin
      user_rx_tvalid <= 1'b0;
      user_rx_tdata  <= '0;
      user_rx_tkeep  <= '0;
      user_rx_tlast  <= 1'b0;
      skid_vld       <= 1'b0;
      skid           <= '0;
    end else if (!user_rx_tvalid || pop) begin
      if (skid_vld) begin
        {user_rx_tdata, user_rx_tkeep, user_rx_tlast} <= skid;
        user_rx_tvalid <= 1'b1;
        skid_vld       <= rd_pend;
        if (rd_pend) skid <= ram_q;
      end else if (rd_pend) begin
        {user_rx_tdata, user_rx_tkeep, user_rx_tlast} <= ram_q;
        user_rx_tvalid <= 1'b1;
      end else begin
        user_rx_tvalid <= 1'b0;
      end
    end else if (rd_pend) begin
      skid     <= ram_q;
      skid_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmac_rx_pkt_filter.sv
// Scoreboard bench for cmac_rx_pkt_filter with DEPTH=16 and 4-bit counters.
module tb_cmac_rx_pkt_filter;

  localparam int DEPTH = 16;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  logic         cmac_clk = 1'b0;
  logic         cmac_reset;
  logic [511:0] cmac_rx_tdata;
  logic [63:0]  cmac_rx_tkeep;
  logic         cmac_rx_tuser, cmac_rx_tlast, cmac_rx_tvalid;
  logic [511:0] user_rx_tdata;
  logic [63:0]  user_rx_tkeep;
  logic         user_rx_tuser, user_rx_tlast, user_rx_tvalid, user_rx_tready;
  logic         clear_counters;
  logic [CNT_W-1:0] good_count, err_drop_count, ovf_drop_count;

  beat_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit rand_done;

  cmac_rx_pkt_filter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .cmac_clk       (cmac_clk),
    .cmac_reset     (cmac_reset),
    .cmac_rx_tdata  (cmac_rx_tdata),
    .cmac_rx_tkeep  (cmac_rx_tkeep),
    .cmac_rx_tuser  (cmac_rx_tuser),
    .cmac_rx_tlast  (cmac_rx_tlast),
    .cmac_rx_tvalid (cmac_rx_tvalid),
    .user_rx_tdata  (user_rx_tdata),
    .user_rx_tkeep  (user_rx_tkeep),
    .user_rx_tuser  (user_rx_tuser),
    .user_rx_tlast  (user_rx_tlast),
    .user_rx_tvalid (user_rx_tvalid),
    .user_rx_tready (user_rx_tready),
    .clear_counters (clear_counters),
    .good_count     (good_count),
    .err_drop_count (err_drop_count),
    .ovf_drop_count (ovf_drop_count)
  );

  always #5 cmac_clk = ~cmac_clk;

  function automatic logic [511:0] beat_data(input int id, input int b);
    logic [31:0] w;
    w = {id[15:0], b[15:0]};
    return {16{w}};
  endfunction

  function automatic logic [63:0] last_keep(input int id);
    logic [63:0] all_ones;
    all_ones = '1;
    return all_ones >> (id % 64);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cmac_clk);
    #1;
  endtask

  task automatic send_pkt(input int id, input int len, input bit err, input bit fwd, input bit clr_last);
    for (int b = 0; b < len; b++) begin
      cmac_rx_tdata  = beat_data(id, b);
      cmac_rx_tkeep  = (b == len - 1) ? last_keep(id) : '1;
      cmac_rx_tlast  = (b == len - 1);
      cmac_rx_tuser  = (b == len - 1) ? err : 1'b0;
      cmac_rx_tvalid = 1'b1;
      clear_counters = clr_last && (b == len - 1);
      if (fwd) exp_q.push_back('{d: cmac_rx_tdata, k: cmac_rx_tkeep, l: cmac_rx_tlast});
      tick();
    end
    cmac_rx_tvalid = 1'b0;
    cmac_rx_tlast  = 1'b0;
    cmac_rx_tuser  = 1'b0;
    clear_counters = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick();
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    beat_t got, e, prev;
    bit prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge cmac_clk);
      got = '{d: user_rx_tdata, k: user_rx_tkeep, l: user_rx_tlast};
      if (prev_stall) begin
        n_tests++;
        if (!user_rx_tvalid || got !== prev) begin
          n_fail++;
          $display("FAIL stall_stable: got valid=%0b beat=%0h, expected valid=1 beat=%0h",
                   user_rx_tvalid, got[63:0], prev[63:0]);
        end
      end
      if (user_rx_tvalid && user_rx_tready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got last=%0b data[31:0]=%0h, expected no beat",
                   user_rx_tlast, user_rx_tdata[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (got !== e || user_rx_tuser !== 1'b0) begin
            n_fail++;
            $display("FAIL beat: got d=%0h k=%0h l=%0b u=%0b, expected d=%0h k=%0h l=%0b u=0",
                     got.d[31:0], got.k, got.l, user_rx_tuser, e.d[31:0], e.k, e.l);
          end
        end
      end
      prev_stall = user_rx_tvalid && !user_rx_tready && !cmac_reset;
      prev = got;
    end
  end

  initial begin
    bit seen;
    int len;
    cmac_reset = 1'b1;
    cmac_rx_tdata = '0; cmac_rx_tkeep = '0; cmac_rx_tuser = 1'b0;
    cmac_rx_tlast = 1'b0; cmac_rx_tvalid = 1'b0;
    user_rx_tready = 1'b1; clear_counters = 1'b0; rand_done = 1'b0;
    repeat (3) tick();
    cmac_reset = 1'b0;
    check("reset_tvalid", 64'(user_rx_tvalid), 64'd0);
    check("reset_tdata_zero", 64'(user_rx_tdata == '0 && user_rx_tkeep == '0 && !user_rx_tlast), 64'd1);
    check("reset_counters", {good_count, err_drop_count, ovf_drop_count}, 64'd0);
    tick();

    // 4-beat good packet; first beat must appear within 3 edges of tlast.
    send_pkt(1, 4, 1'b0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!seen) begin
        tick();
        if (user_rx_tvalid) seen = 1'b1;
      end
    end
    check("first_beat_latency", 64'(seen), 64'd1);
    drain();
    check("t1_good", 64'(good_count), 64'd1);

    // Errored packet followed by a good one.
    send_pkt(2, 3, 1'b1, 1'b0, 1'b0);
    send_pkt(3, 2, 1'b0, 1'b1, 1'b0);
    drain();
    check("t2_err", 64'(err_drop_count), 64'd1);
    check("t2_good", 64'(good_count), 64'd2);
    check("t2_idle", 64'(user_rx_tvalid), 64'd0);

    // Overflow of the second packet while output stalled; third must survive.
    user_rx_tready = 1'b0;
    send_pkt(4, 10, 1'b0, 1'b1, 1'b0);
    send_pkt(5, 10, 1'b0, 1'b0, 1'b0);
    send_pkt(6, 2, 1'b0, 1'b1, 1'b0);
    repeat (5) tick();
    check("t3_ovf", 64'(ovf_drop_count), 64'd1);
    check("t3_good", 64'(good_count), 64'd4);
    check("t3_stalled_valid", 64'(user_rx_tvalid), 64'd1);
    user_rx_tready = 1'b1;
    drain();

    // Packet longer than DEPTH, then a normal packet.
    send_pkt(7, 20, 1'b0, 1'b0, 1'b0);
    send_pkt(8, 4, 1'b0, 1'b1, 1'b0);
    drain();
    check("t4_ovf", 64'(ovf_drop_count), 64'd2);
    check("t4_good", 64'(good_count), 64'd5);

    // Reset arriving with beat 2 of 5, tvalid held continuously.
    for (int b = 0; b < 5; b++) begin
      cmac_rx_tdata  = beat_data(9, b);
      cmac_rx_tkeep  = '1;
      cmac_rx_tlast  = (b == 4);
      cmac_rx_tvalid = 1'b1;
      cmac_reset     = (b == 1);
      tick();
      if (b == 1) check("t5_counters_after_reset", {good_count, err_drop_count, ovf_drop_count}, 64'd0);
    end
    cmac_reset = 1'b0;
    send_pkt(10, 3, 1'b0, 1'b1, 1'b0);
    drain();
    check("t5_good", 64'(good_count), 64'd1);
    check("t5_drops", {err_drop_count, ovf_drop_count}, 64'd0);

    // Reset with a stalled output beat.
    user_rx_tready = 1'b0;
    send_pkt(11, 3, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    check("t6_stalled_valid", 64'(user_rx_tvalid), 64'd1);
    cmac_reset = 1'b1;
    tick();
    check("t6_valid_after_reset", 64'(user_rx_tvalid), 64'd0);
    check("t6_good_after_reset", 64'(good_count), 64'd0);
    cmac_reset = 1'b0;
    user_rx_tready = 1'b1;
    tick();

    // 100 packets with random ready; sender keeps the buffer from overflowing.
    fork
      begin
        for (int id = 100; id < 200; id++) begin
          len = 1 + (id % 4);
          for (int w = 0; w < 1000 && exp_q.size() + len > DEPTH; w++) tick();
          send_pkt(id, len, 1'b0, 1'b1, 1'b0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          user_rx_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    user_rx_tready = 1'b1;
    drain();
    check("t7_good_saturated", 64'(good_count), 64'd15);
    check("t7_drops", {err_drop_count, ovf_drop_count}, 64'd0);

    // clear_counters coincident with a commit.
    send_pkt(300, 2, 1'b0, 1'b1, 1'b1);
    drain();
    check("t8_clear_wins", 64'(good_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
